// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - push-side and serial-side signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          i_Tx_DV;
    logic [7:0]    i_Tx_Byte;
    logic          o_Tx_Ready;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Tx_Done;
    logic [CW-1:0] o_Fifo_Count;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small byte FIFO, gapless frames
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         i_Clock,
    input  logic         i_Resetn,
    uart_tx_fifo_if.slave tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state, w_state_nxt;
    logic [15:0]   r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_serial, w_serial_nxt;
    logic          r_active, w_active_nxt;
    logic          r_done, w_done_nxt;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_ready;

    logic w_push, w_pop, w_empty, w_bit_end;

    assign w_empty   = (r_count == '0);
    assign w_push    = tx.i_Tx_DV && r_ready;
    assign w_bit_end = (r_clk_cnt == LAST_CNT);

    // Ready is registered from the post-edge count, so a push on a pop edge into a full FIFO is refused.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= tx.i_Tx_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_serial_nxt  = r_serial;
        w_active_nxt  = r_active;
        w_done_nxt    = 1'b0;
        w_clk_cnt_nxt = r_clk_cnt + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        case (r_state)
            S_IDLE: begin
                w_serial_nxt  = 1'b1;
                w_active_nxt  = 1'b0;
                w_clk_cnt_nxt = '0;
                if (w_pop) begin
                    w_shift_nxt  = r_mem[r_rd_ptr];
                    w_serial_nxt = 1'b0;
                    w_active_nxt = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_serial_nxt  = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_serial_nxt  = 1'b1;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_serial_nxt  = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_done_nxt    = 1'b1;
                    // Next start bit goes out on the same edge the stop bit ends.
                    if (w_pop) begin
                        w_shift_nxt  = r_mem[r_rd_ptr];
                        w_serial_nxt = 1'b0;
                    end else begin
                        w_active_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_serial_nxt  = 1'b1;
                w_active_nxt  = 1'b0;
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_serial  <= w_serial_nxt;
            r_active  <= w_active_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign tx.o_Tx_Ready   = r_ready;
    assign tx.o_Tx_Serial  = r_serial;
    assign tx.o_Tx_Active  = r_active;
    assign tx.o_Tx_Done    = r_done;
    assign tx.o_Fifo_Count = r_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo at 4 and 1 clocks per bit
module tb_uart_tx_fifo;
    localparam int CPB_A = 4;
    localparam int CPB_B = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) a_if ();
    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) b_if ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_Clock(clk), .i_Resetn(rst_n_a), .tx(a_if.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_Clock(clk), .i_Resetn(rst_n_b), .tx(b_if.slave));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frames_a = 0;
    int done_cnt_a = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int starts_a[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (a_if.o_Tx_Done === 1'b1) done_cnt_a <= done_cnt_a + 1;

    // Frame checker for instance A: every cycle of every bit is compared against the scoreboard head.
    initial begin : mon_a
        logic [9:0] bits;
        logic [9:0] got;
        logic [7:0] exp;
        bit hold, bad, aborted;
        int n;
        hold = 0;
        forever begin
            if (!hold) @(negedge clk);
            hold = 0;
            if (rst_n_a === 1'b1 && a_if.o_Tx_Serial === 1'b0) begin
                starts_a.push_back(cyc);
                bad = 0;
                if (exp_a.size() == 0) begin
                    exp = 8'h00;
                    bad = 1;
                end else begin
                    exp = exp_a.pop_front();
                end
                bits = {1'b1, exp, 1'b0};
                got = '0;
                aborted = 0;
                n = 0;
                while (n < 10 * CPB_A && !aborted) begin
                    if (n > 0) @(negedge clk);
                    if (rst_n_a !== 1'b1) begin
                        aborted = 1;
                    end else begin
                        if (a_if.o_Tx_Serial !== bits[n / CPB_A]) bad = 1;
                        if ((n % CPB_A) == CPB_A / 2) got[n / CPB_A] = a_if.o_Tx_Serial;
                    end
                    n++;
                end
                if (!aborted) begin
                    frames_a++;
                    tests++;
                    if (bad) begin
                        fails++;
                        $display("FAIL frame_a got bits %b required %b (queue empty=%0d)",
                                 got, bits, (exp_a.size() == 0));
                    end
                    @(negedge clk);
                    if (rst_n_a === 1'b1) begin
                        tests++;
                        if (a_if.o_Tx_Done !== 1'b1) begin
                            fails++;
                            $display("FAIL done_after_stop got %b required 1", a_if.o_Tx_Done);
                        end
                    end
                    hold = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle_a();
        int n = 0;
        while (!(exp_a.size() == 0 && a_if.o_Tx_Active === 1'b0 && a_if.o_Tx_Serial === 1'b1)
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL wait_idle_a timeout got pending=%0d required 0", exp_a.size());
        end
    endtask

    task automatic test_reset();
        a_if.i_Tx_DV = 1'b0; a_if.i_Tx_Byte = 8'h00;
        b_if.i_Tx_DV = 1'b0; b_if.i_Tx_Byte = 8'h00;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (3) @(negedge clk);
        tests += 6;
        if (a_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL rst_serial got %b required 1", a_if.o_Tx_Serial); end
        if (a_if.o_Tx_Active !== 1'b0) begin fails++; $display("FAIL rst_active got %b required 0", a_if.o_Tx_Active); end
        if (a_if.o_Tx_Done !== 1'b0) begin fails++; $display("FAIL rst_done got %b required 0", a_if.o_Tx_Done); end
        if (a_if.o_Tx_Ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b required 1", a_if.o_Tx_Ready); end
        if (a_if.o_Fifo_Count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d required 0", a_if.o_Fifo_Count); end
        if (b_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL rst_serial_b got %b required 1", b_if.o_Tx_Serial); end
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int d0 = done_cnt_a;
        int act = 0;
        a_if.i_Tx_DV = 1'b1; a_if.i_Tx_Byte = 8'hA5;
        exp_a.push_back(8'hA5);
        @(negedge clk);
        a_if.i_Tx_DV = 1'b0;
        tests += 2;
        if (a_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL single_pre_start got %b required 1", a_if.o_Tx_Serial); end
        if (a_if.o_Fifo_Count !== 3'd1) begin fails++; $display("FAIL single_count got %0d required 1", a_if.o_Fifo_Count); end
        @(negedge clk);
        tests++;
        if (a_if.o_Tx_Serial !== 1'b0) begin fails++; $display("FAIL single_latency got %b required 0", a_if.o_Tx_Serial); end
        for (int c = 0; c < 60; c++) begin
            if (a_if.o_Tx_Active === 1'b1) act++;
            @(negedge clk);
        end
        tests += 2;
        if (act != 40) begin fails++; $display("FAIL single_active_cycles got %0d required 40", act); end
        if (done_cnt_a - d0 != 1) begin fails++; $display("FAIL single_done_pulses got %0d required 1", done_cnt_a - d0); end
        wait_idle_a();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b3 [3] = '{8'h00, 8'hFF, 8'h55};
        int d0;
        wait_idle_a();
        starts_a.delete();
        d0 = done_cnt_a;
        for (int i = 0; i < 3; i++) begin
            a_if.i_Tx_DV = 1'b1; a_if.i_Tx_Byte = b3[i];
            exp_a.push_back(b3[i]);
            @(negedge clk);
            if (i == 0) begin
                tests++;
                if (a_if.o_Fifo_Count !== 3'd1) begin fails++; $display("FAIL b2b_count0 got %0d required 1", a_if.o_Fifo_Count); end
            end
        end
        a_if.i_Tx_DV = 1'b0;
        tests++;
        if (a_if.o_Fifo_Count !== 3'd2) begin fails++; $display("FAIL b2b_count2 got %0d required 2", a_if.o_Fifo_Count); end
        wait_idle_a();
        tests += 2;
        if (starts_a.size() != 3) begin
            fails++; $display("FAIL b2b_frames got %0d required 3", starts_a.size());
        end else if (starts_a[1] - starts_a[0] != 40 || starts_a[2] - starts_a[1] != 40) begin
            fails++; $display("FAIL b2b_spacing got %0d,%0d required 40,40",
                              starts_a[1] - starts_a[0], starts_a[2] - starts_a[1]);
        end
        if (done_cnt_a - d0 != 3) begin fails++; $display("FAIL b2b_done got %0d required 3", done_cnt_a - d0); end
    endtask

    task automatic test_overflow();
        logic [7:0] b6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int k = 0;
        int acc = 0;
        int f0;
        bit saw_full = 0;
        wait_idle_a();
        f0 = frames_a;
        for (int c = 0; c < 16; c++) begin
            a_if.i_Tx_DV = 1'b1; a_if.i_Tx_Byte = b6[k];
            if (a_if.o_Tx_Ready === 1'b1) begin
                exp_a.push_back(b6[k]);
                acc++;
                if (k < 5) k++;
            end
            @(negedge clk);
            if (a_if.o_Fifo_Count === 3'd4 && a_if.o_Tx_Ready === 1'b0) saw_full = 1;
        end
        a_if.i_Tx_DV = 1'b0;
        tests += 2;
        if (acc != 5) begin fails++; $display("FAIL ovf_accepted got %0d required 5", acc); end
        if (!saw_full) begin fails++; $display("FAIL ovf_ready_drop got 0 required 1"); end
        wait_idle_a();
        tests++;
        if (frames_a - f0 != 5) begin fails++; $display("FAIL ovf_frames got %0d required 5", frames_a - f0); end
    endtask

    task automatic test_full_pop();
        int n = 0;
        wait_idle_a();
        for (int i = 0; i < 5; i++) begin
            a_if.i_Tx_DV = 1'b1; a_if.i_Tx_Byte = 8'hB0 + 8'(i);
            exp_a.push_back(8'hB0 + 8'(i));
            @(negedge clk);
        end
        tests++;
        if (a_if.o_Fifo_Count !== 3'd4) begin fails++; $display("FAIL fullpop_fill got %0d required 4", a_if.o_Fifo_Count); end
        a_if.i_Tx_Byte = 8'hC3;
        while (a_if.o_Tx_Ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests += 2;
        if (n >= 100) begin fails++; $display("FAIL fullpop_ready_timeout got %0d required <100", n); end
        if (a_if.o_Tx_Done !== 1'b1) begin fails++; $display("FAIL fullpop_ready_on_load got done=%b required 1", a_if.o_Tx_Done); end
        exp_a.push_back(8'hC3);
        @(negedge clk);
        a_if.i_Tx_DV = 1'b0;
        tests += 2;
        if (a_if.o_Fifo_Count !== 3'd4) begin fails++; $display("FAIL fullpop_count got %0d required 4", a_if.o_Fifo_Count); end
        if (a_if.o_Tx_Ready !== 1'b0) begin fails++; $display("FAIL fullpop_ready_after got %b required 0", a_if.o_Tx_Ready); end
        wait_idle_a();
    endtask

    task automatic test_reset_mid();
        int f0;
        bit saw_low = 0;
        wait_idle_a();
        f0 = frames_a;
        for (int i = 0; i < 3; i++) begin
            a_if.i_Tx_DV = 1'b1; a_if.i_Tx_Byte = 8'h0F + 8'(i);
            exp_a.push_back(8'h0F + 8'(i));
            @(negedge clk);
        end
        a_if.i_Tx_DV = 1'b0;
        repeat (16) @(negedge clk);
        tests++;
        if (a_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL rmid_bit3 got %b required 1", a_if.o_Tx_Serial); end
        #1 rst_n_a = 1'b0;
        #1;
        tests += 3;
        if (a_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL rmid_serial got %b required 1", a_if.o_Tx_Serial); end
        if (a_if.o_Fifo_Count !== 3'd0) begin fails++; $display("FAIL rmid_count got %0d required 0", a_if.o_Fifo_Count); end
        if (a_if.o_Tx_Active !== 1'b0) begin fails++; $display("FAIL rmid_active got %b required 0", a_if.o_Tx_Active); end
        exp_a.delete();
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (a_if.o_Tx_Serial !== 1'b1) saw_low = 1;
        end
        tests += 2;
        if (saw_low) begin fails++; $display("FAIL rmid_line_after got low required high"); end
        if (frames_a != f0) begin fails++; $display("FAIL rmid_frames got %0d required 0", frames_a - f0); end
    endtask

    task automatic test_cpb1();
        logic [7:0] exp;
        logic [9:0] got;
        logic [9:0] want;
        b_if.i_Tx_DV = 1'b1; b_if.i_Tx_Byte = 8'h81;
        exp_b.push_back(8'h81);
        @(negedge clk);
        b_if.i_Tx_DV = 1'b0;
        @(negedge clk);
        exp = exp_b.pop_front();
        want = {1'b1, exp, 1'b0};
        for (int n = 0; n < 10; n++) begin
            got[n] = b_if.o_Tx_Serial;
            if (n < 9) @(negedge clk);
        end
        tests++;
        if (got !== want) begin fails++; $display("FAIL cpb1_frame got %b required %b", got, want); end
        @(negedge clk);
        tests += 3;
        if (b_if.o_Tx_Done !== 1'b1) begin fails++; $display("FAIL cpb1_done got %b required 1", b_if.o_Tx_Done); end
        if (b_if.o_Tx_Serial !== 1'b1) begin fails++; $display("FAIL cpb1_idle_line got %b required 1", b_if.o_Tx_Serial); end
        if (b_if.o_Tx_Active !== 1'b0) begin fails++; $display("FAIL cpb1_active got %b required 0", b_if.o_Tx_Active); end
        @(negedge clk);
        tests++;
        if (b_if.o_Tx_Done !== 1'b0) begin fails++; $display("FAIL cpb1_done_width got %b required 0", b_if.o_Tx_Done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_cpb1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
